// File: rtl/ariane_pkg.sv
// Shared divider definitions: opcode encoding, FSM states and transaction id width.
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [1:0] {
        DIV_UDIV = 2'd0,
        DIV_DIV  = 2'd1,
        DIV_UREM = 2'd2,
        DIV_REM  = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_DIVIDE,
        DIV_FINISH
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (div_op_e'(op) == DIV_DIV) || (div_op_e'(op) == DIV_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (div_op_e'(op) == DIV_UREM) || (div_op_e'(op) == DIV_REM);
    endfunction

endpackage

// File: rtl/lzc.sv
// Leading-zero counter; cnt_o is 0 and empty_o is 1 for an all-zero input.
module lzc #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] cnt_o,
    output logic                     empty_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_i[i]) begin
                cnt_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/serdiv_ct.sv
// Serial restoring divider with an optional constant-time mode (fixed WIDTH-cycle DIVIDE).
module serdiv_ct
    import ariane_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter logic        FORCE_CT = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [TRANS_ID_BITS-1:0] id_i,
    input  logic [WIDTH-1:0]         op_a_i,
    input  logic [WIDTH-1:0]         op_b_i,
    input  logic [1:0]               opcode_i,
    input  logic                     op_w_i,
    input  logic                     ct_en_i,
    input  logic                     in_vld_i,
    output logic                     in_rdy_o,
    input  logic                     flush_i,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic [TRANS_ID_BITS-1:0] id_o,
    output logic [WIDTH-1:0]         res_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned LZC_W = $clog2(WIDTH);

    div_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]         rem_q, rem_d;
    logic [WIDTH-1:0]         quo_q, quo_d;
    logic [WIDTH-1:0]         div_q, div_d;
    logic                     rem_sel_q, rem_sel_d;
    logic                     neg_quo_q, neg_quo_d;
    logic                     neg_rem_q, neg_rem_d;
    logic                     word_q, word_d;
    logic                     ct_q, ct_d;
    logic                     skip_q, skip_d;
    logic [TRANS_ID_BITS-1:0] id_q, id_d;

    logic             signed_op, ct_req;
    logic [WIDTH-1:0] a_ext, b_ext, a_abs, b_abs;
    logic             a_neg, b_neg, b_is_zero, b_neg1, b_gt_a, special;
    logic [LZC_W-1:0] lzc_a, lzc_b;
    logic             a_empty, b_empty;
    logic [CNT_W-1:0] iters;
    logic [WIDTH-1:0] rem_init, quo_init;
    logic [WIDTH:0]   step_tmp, step_diff;
    logic             step_bit;
    logic [WIDTH-1:0] res_full;

    assign signed_op = op_is_signed(opcode_i);
    assign ct_req    = ct_en_i | FORCE_CT;

    if (WIDTH > 32) begin : g_word
        assign a_ext = op_w_i ? {{(WIDTH-32){signed_op & op_a_i[31]}}, op_a_i[31:0]} : op_a_i;
        assign b_ext = op_w_i ? {{(WIDTH-32){signed_op & op_b_i[31]}}, op_b_i[31:0]} : op_b_i;
        assign res_o = word_q ? {{(WIDTH-32){res_full[31]}}, res_full[31:0]} : res_full;
    end else begin : g_noword
        assign a_ext = op_a_i;
        assign b_ext = op_b_i;
        assign res_o = res_full;
    end

    assign a_neg     = signed_op & a_ext[WIDTH-1];
    assign b_neg     = signed_op & b_ext[WIDTH-1];
    assign a_abs     = a_neg ? -a_ext : a_ext;
    assign b_abs     = b_neg ? -b_ext : b_ext;
    assign b_is_zero = ~|b_ext;
    assign b_neg1    = signed_op & (&b_ext);
    assign b_gt_a    = b_abs > a_abs;

    lzc #(.WIDTH(WIDTH)) i_lzc_a (.in_i(a_abs), .cnt_o(lzc_a), .empty_o(a_empty));
    lzc #(.WIDTH(WIDTH)) i_lzc_b (.in_i(b_abs), .cnt_o(lzc_b), .empty_o(b_empty));

    assign special = b_empty | a_empty | b_neg1 | b_gt_a;

    // Non-CT alignment: pre-shifting the dividend by shift+1 is equivalent to aligning
    // the divisor, and leaves only the shift+1 low quotient bits to compute.
    always_comb begin
        iters    = CNT_W'(LZC_W'(lzc_b - lzc_a)) + CNT_W'(1);
        rem_init = a_abs >> iters;
        quo_init = a_abs << (CNT_W'(WIDTH) - iters);
        if (ct_req) begin
            iters    = CNT_W'(WIDTH);
            rem_init = '0;
            quo_init = a_abs;
        end else if (special) begin
            iters = CNT_W'(1);
            if (b_empty) begin
                quo_init = '1;
                rem_init = a_abs;
            end else if (b_neg1) begin
                quo_init = a_abs;
                rem_init = '0;
            end else begin
                quo_init = '0;
                rem_init = a_abs;
            end
        end
    end

    assign step_tmp  = {rem_q, quo_q[WIDTH-1]};
    assign step_diff = step_tmp - {1'b0, div_q};
    assign step_bit  = ~step_diff[WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        word_d    = word_q;
        ct_d      = ct_q;
        skip_d    = skip_q;
        id_d      = id_q;
        in_rdy_o  = 1'b0;
        out_vld_o = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                in_rdy_o = ~flush_i;
                if (in_vld_i && !flush_i) begin
                    state_d   = DIV_DIVIDE;
                    cnt_d     = iters;
                    rem_d     = rem_init;
                    quo_d     = quo_init;
                    div_d     = b_abs;
                    rem_sel_d = op_is_rem(opcode_i);
                    neg_quo_d = (a_neg ^ b_neg) & ~b_is_zero;
                    neg_rem_d = a_neg;
                    word_d    = op_w_i;
                    ct_d      = ct_req;
                    skip_d    = ~ct_req & special;
                    id_d      = id_i;
                end
            end
            DIV_DIVIDE: begin
                if (ct_q || !skip_q) begin
                    rem_d = step_bit ? step_diff[WIDTH-1:0] : step_tmp[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], step_bit};
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DIV_FINISH;
                end
            end
            DIV_FINISH: begin
                out_vld_o = ~flush_i;
                if (out_rdy_i) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        if (flush_i) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            word_q    <= 1'b0;
            ct_q      <= 1'b0;
            skip_q    <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            word_q    <= word_d;
            ct_q      <= ct_d;
            skip_q    <= skip_d;
            id_q      <= id_d;
        end
    end

    assign res_full = rem_sel_q ? (neg_rem_q ? -rem_q : rem_q)
                                : (neg_quo_q ? -quo_q : quo_q);
    assign id_o     = id_q;

endmodule

// File: tb/tb_serdiv_ct.sv
// Directed bench for serdiv_ct: vector table plus flush, stall and reset sequences.
module tb_serdiv_ct;
    import ariane_pkg::*;

    localparam int unsigned W = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [TRANS_ID_BITS-1:0] id_i;
    logic [W-1:0]             op_a, op_b;
    logic [1:0]               opcode;
    logic                     op_w, ct_en, in_vld, flush, out_rdy;
    logic                     in_rdy, out_vld;
    logic [TRANS_ID_BITS-1:0] id_o;
    logic [W-1:0]             res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serdiv_ct #(.WIDTH(W), .FORCE_CT(1'b0)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .id_i     (id_i),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .opcode_i (opcode),
        .op_w_i   (op_w),
        .ct_en_i  (ct_en),
        .in_vld_i (in_vld),
        .in_rdy_o (in_rdy),
        .flush_i  (flush),
        .out_vld_o(out_vld),
        .out_rdy_i(out_rdy),
        .id_o     (id_o),
        .res_o    (res)
    );

    typedef struct {
        logic [1:0]  op;
        logic        w;
        logic        ct;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns after its accept edge (now in the first DIVIDE cycle).
    task automatic start(input logic [2:0] id, input vec_t v, input string nm);
        @(negedge clk);
        in_vld = 1'b1; id_i = id; opcode = v.op; op_w = v.w; ct_en = v.ct;
        op_a = v.a; op_b = v.b;
        #1;
        chk({nm, ".in_rdy"}, 64'(in_rdy), 64'd1);
        tick();
        in_vld = 1'b0;
    endtask

    task automatic wait_vld(output int lat);
        lat = 1;
        while (!out_vld && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input logic [2:0] id, input vec_t v, input string nm);
        int lat;
        start(id, v, nm);
        wait_vld(lat);
        chk({nm, ".lat"}, 64'(lat), 64'(v.lat));
        chk({nm, ".res"}, res, v.res);
        chk({nm, ".id"}, 64'(id_o), 64'(id));
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        #1;
        chk({nm, ".vld_clr"}, 64'(out_vld), 64'd0);
    endtask

    task automatic idle_watch(input string nm);
        int seen = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (out_vld) seen++;
        end
        chk(nm, 64'(seen), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   lat;

        //            op     w     ct    a                        b                        res                      lat
        vecs[0]  = '{2'd1, 1'b0, 1'b1, 64'd100,                 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65};
        vecs[1]  = '{2'd2, 1'b0, 1'b1, 64'd5,                   64'd0,                   64'd5,                   65};
        vecs[2]  = '{2'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[3]  = '{2'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2};
        vecs[4]  = '{2'd3, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   2};
        vecs[5]  = '{2'd1, 1'b1, 1'b0, 64'h1_8000_0000,         64'd2,                   64'hFFFF_FFFF_C000_0000, 32};
        vecs[6]  = '{2'd0, 1'b0, 1'b1, 64'd7,                   64'd2,                   64'd3,                   65};
        vecs[7]  = '{2'd0, 1'b0, 1'b0, 64'd7,                   64'd2,                   64'd3,                   3};
        vecs[8]  = '{2'd2, 1'b0, 1'b0, 64'd7,                   64'd2,                   64'd1,                   3};
        vecs[9]  = '{2'd0, 1'b0, 1'b0, 64'd3,                   64'd10,                  64'd0,                   2};
        vecs[10] = '{2'd2, 1'b0, 1'b0, 64'd3,                   64'd10,                  64'd3,                   2};
        vecs[11] = '{2'd0, 1'b0, 1'b0, 64'd9,                   64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 2};
        vecs[12] = '{2'd3, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 3};
        vecs[13] = '{2'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 3};
        vecs[14] = '{2'd3, 1'b0, 1'b1, 64'd100,                 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   65};
        vecs[15] = '{2'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_000A, 64'd3,                   64'd1,                   4};
        vecs[16] = '{2'd0, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1,                   64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[17] = '{2'd1, 1'b0, 1'b0, 64'd5,                   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 2};

        rst = 1'b1; in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b0;
        id_i = '0; op_a = '0; op_b = '0; opcode = '0; op_w = 1'b0; ct_en = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("reset.in_rdy", 64'(in_rdy), 64'd1);
        chk("reset.out_vld", 64'(out_vld), 64'd0);
        chk("reset.res", res, 64'd0);
        chk("reset.id", 64'(id_o), 64'd0);

        for (int i = 0; i < 18; i++) begin
            do_op(3'(i), vecs[i], $sformatf("vec%0d", i));
        end

        // Flush while IDLE: request ignored, still ready afterwards.
        @(negedge clk);
        in_vld = 1'b1; flush = 1'b1; opcode = 2'd0; op_a = 64'd7; op_b = 64'd2; ct_en = 1'b0;
        #1;
        chk("idle_flush.in_rdy", 64'(in_rdy), 64'd0);
        tick();
        in_vld = 1'b0; flush = 1'b0;
        #1;
        chk("idle_flush.still_idle", 64'(in_rdy), 64'd1);
        idle_watch("idle_flush.no_vld");

        // Flush on the 10th DIVIDE cycle.
        v = '{2'd0, 1'b0, 1'b1, 64'd1000, 64'd3, 64'd333, 65};
        start(3'd5, v, "flush");
        repeat (9) tick();
        flush = 1'b1;
        #1;
        chk("flush.out_vld", 64'(out_vld), 64'd0);
        chk("flush.in_rdy", 64'(in_rdy), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush.idle_next", 64'(in_rdy), 64'd1);
        idle_watch("flush.no_vld");
        v = '{2'd0, 1'b0, 1'b0, 64'd7, 64'd2, 64'd3, 3};
        do_op(3'd6, v, "after_flush");

        // Result held while out_rdy_i stays low, then flush beats out_rdy_i.
        v = '{2'd0, 1'b0, 1'b0, 64'd7, 64'd2, 64'd3, 3};
        start(3'd2, v, "hold");
        wait_vld(lat);
        chk("hold.lat", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d.vld", i), 64'(out_vld), 64'd1);
            chk($sformatf("hold%0d.res", i), res, 64'd3);
            chk($sformatf("hold%0d.id", i), 64'(id_o), 64'd2);
            chk($sformatf("hold%0d.in_rdy", i), 64'(in_rdy), 64'd0);
            tick();
        end
        flush = 1'b1; out_rdy = 1'b1;
        #1;
        chk("flush_rdy.out_vld", 64'(out_vld), 64'd0);
        tick();
        flush = 1'b0; out_rdy = 1'b0;
        #1;
        chk("flush_rdy.idle", 64'(in_rdy), 64'd1);
        chk("flush_rdy.vld", 64'(out_vld), 64'd0);

        // Reset mid-DIVIDE discards the operation.
        v = '{2'd1, 1'b0, 1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 65};
        start(3'd3, v, "rst_mid");
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid.in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_mid.out_vld", 64'(out_vld), 64'd0);
        chk("rst_mid.res", res, 64'd0);
        chk("rst_mid.id", 64'(id_o), 64'd0);
        idle_watch("rst_mid.no_vld");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serdiv_ct.md
SERDIV_CT -- requirements
Module: serdiv_ct

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width (32 or 64).
REQ-002 SHALL have parameter FORCE_CT, default 1, which forces constant-time mode regardless of ct_en_i.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 id_i  in  TRANS_ID_BITS  transaction id, captured on accept.
REQ-006 op_a_i / op_b_i  in  WIDTH  dividend / divisor.
REQ-007 opcode_i  in  2  0 udiv, 1 div, 2 urem, 3 rem.
REQ-008 op_w_i  in  1  word op: use low 32 bits; result sign-extended from bit 31 (WIDTH=64 only, ignored when WIDTH=32).
REQ-009 ct_en_i  in  1  request constant-time execution for this operation.
REQ-010 in_vld_i in 1 / in_rdy_o out 1  input handshake.
REQ-011 flush_i  in  1  abort the current operation.
REQ-012 out_vld_o out 1 / out_rdy_i in 1  output handshake.
REQ-013 id_o  out  TRANS_ID_BITS  id of the current result.
REQ-014 res_o  out  WIDTH  quotient or remainder.

Function
REQ-015 SHALL implement states IDLE, DIVIDE, FINISH.
REQ-016 in_rdy_o SHALL be 1 only in IDLE with flush_i=0; an operation is accepted when in_vld_i & in_rdy_o.
REQ-017 Accept SHALL capture operands, opcode flags, id and CT flag (ct_en_i | FORCE_CT) and move to DIVIDE.
REQ-018 Word op SHALL extend the low 32 bits first (sign-extend for opcode[0]=1, zero-extend otherwise), then divide at full width.
REQ-019 Division SHALL be restoring, one quotient bit per cycle, on magnitudes; signs applied at the output.
REQ-020 CT mode: DIVIDE SHALL last exactly WIDTH cycles for every operand value, special cases included; no early exit, no leading-zero alignment.
REQ-021 CT mode: first out_vld_o cycle SHALL be accept cycle + WIDTH + 1.
REQ-022 Non-CT mode SHALL align the divisor by its leading-zero difference, iterate shift+1 cycles, and finish after 1 DIVIDE cycle when |b|>|a|, b=0, or signed b=-1.
REQ-023 Divide by zero: quotient all ones; remainder = dividend (after word extension).
REQ-024 Signed overflow (most-negative / -1): quotient = dividend; remainder 0.
REQ-025 Remainder sign SHALL follow the dividend; quotient is negated iff signs differ and b!=0.
REQ-026 FINISH SHALL hold out_vld_o=1, res_o and id_o stable until out_rdy_i=1, then return to IDLE; the next accept is possible no earlier than the following cycle.
REQ-027 out_vld_o SHALL be 0 outside FINISH.
REQ-028 flush_i=1 SHALL force out_vld_o=0 and in_rdy_o=0 that cycle, and IDLE next cycle from any state; in_vld_i is ignored that cycle.
REQ-029 flush_i and out_rdy_i both high in FINISH: flush wins; no handshake completes.
REQ-030 Iteration counter SHALL be $clog2(WIDTH)+1 bits and SHALL not wrap.

Reset
REQ-031 rst_i SHALL put the block in IDLE; all datapath registers 0, id 0, all flags 0.
REQ-032 Outputs after reset: in_rdy_o=1, out_vld_o=0, res_o=0, id_o=0.
REQ-033 Reset mid-DIVIDE or mid-FINISH SHALL discard the operation; no out_vld_o follows.

Structure
REQ-034 Opcode encoding, state enum and TRANS_ID_BITS SHALL live in the shared ariane_pkg.
REQ-035 The existing lzc cell SHALL be the only sub-module (two instances, non-CT alignment); in CT mode lzc results are unused.
REQ-036 The state, counter and datapath toggle count in CT mode SHALL not depend on operand values.

Verification
REQ-037 WIDTH=64, CT, div 100 / -7 -> res 0xFFFF_FFFF_FFFF_FFF2 (-14), out_vld_o exactly 65 cycles after accept.
REQ-038 CT, urem 5 / 0 and udiv 0xFFFF_FFFF_FFFF_FFFF / 1 -> 5 and all ones, both at latency 65 cycles.
REQ-039 Non-CT, div 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 with out_vld_o 2 cycles after accept; rem -> 0.
REQ-040 op_w_i=1, div op_a=0x1_8000_0000, op_b=2 -> 0xFFFF_FFFF_C000_0000.
REQ-041 flush_i pulsed on the 10th DIVIDE cycle -> IDLE next cycle, no out_vld_o; the next op 7/2 returns 3 with its own id.
REQ-042 out_rdy_i held 0 for 5 cycles in FINISH -> res_o/id_o stable, in_rdy_o=0; rst_i mid-DIVIDE -> reset outputs next cycle.
